// File: rtl/mountaincar_step_ctrl.sv
// Episode/step sequencer for MountainCar: accepts agent reset/action requests,
// launches the velocity then position units, and presents the observation.
module mountaincar_step_ctrl #(
  parameter int VEL_WL    = 32,
  parameter int POS_WL    = 32,
  parameter int ACT_WL    = 2,
  parameter int MAX_STEPS = 200,
  parameter int TIMEOUT   = 64,
  parameter int CNT_WL    = 8
) (
  input  logic              i_clk,
  input  logic              i_rst,
  input  logic              i_rst_req_valid,
  output logic              o_rst_req_ready,
  input  logic [POS_WL-1:0] i_init_pos,
  input  logic              i_act_valid,
  output logic              o_act_ready,
  input  logic [ACT_WL-1:0] i_act,
  output logic              o_vel_ena,
  output logic [POS_WL-1:0] o_vel_pos,
  output logic [VEL_WL-1:0] o_vel_vel,
  output logic [ACT_WL-1:0] o_vel_act,
  input  logic              i_vel_valid,
  input  logic [VEL_WL-1:0] i_vel_data,
  output logic              o_pos_ena,
  output logic [POS_WL-1:0] o_pos_pos,
  output logic [VEL_WL-1:0] o_pos_vel,
  input  logic              i_pos_valid,
  input  logic [POS_WL-1:0] i_pos_data,
  output logic              o_obs_valid,
  input  logic              i_obs_ready,
  output logic [POS_WL-1:0] o_obs_pos,
  output logic [VEL_WL-1:0] o_obs_vel,
  output logic [31:0]       o_reward,
  output logic              o_terminated,
  output logic              o_truncated,
  output logic              o_error
);

  localparam int WD_WL = $clog2(TIMEOUT + 1);

  localparam logic [2:0] S_IDLE  = 3'd0;
  localparam logic [2:0] S_READY = 3'd1;
  localparam logic [2:0] S_VEL   = 3'd2;
  localparam logic [2:0] S_POS   = 3'd3;
  localparam logic [2:0] S_OUT   = 3'd4;
  localparam logic [2:0] S_DONE  = 3'd5;
  localparam logic [2:0] S_ERR   = 3'd6;

  localparam logic [POS_WL-1:0] POS_MIN  = 32'hBF99999A;
  localparam logic [POS_WL-2:0] GOAL_MAG = 31'h3F000000;
  localparam logic [31:0]       REW_STEP = 32'hBF800000;

  logic [2:0]        r_state;
  logic [POS_WL-1:0] r_pos;
  logic [VEL_WL-1:0] r_vel;
  logic [VEL_WL-1:0] r_vel_new;
  logic [ACT_WL-1:0] r_act;
  logic [CNT_WL-1:0] r_cnt;
  logic [WD_WL-1:0]  r_wdog;
  logic [31:0]       r_reward;
  logic              r_term;
  logic              r_trunc;
  logic              r_vel_ena;
  logic              r_pos_ena;

  logic w_rst_xfer;
  logic w_act_xfer;
  logic w_wall_hit;
  logic w_goal;

  always_comb begin
    o_rst_req_ready = (r_state == S_IDLE) || (r_state == S_READY) || (r_state == S_DONE);
    // A simultaneous reset request pre-empts the action, so refuse the action.
    o_act_ready     = (r_state == S_READY) && !i_rst_req_valid;
    w_rst_xfer      = i_rst_req_valid && o_rst_req_ready;
    w_act_xfer      = i_act_valid && o_act_ready;
    w_wall_hit      = (i_pos_data == POS_MIN) && r_vel_new[VEL_WL-1] && (|r_vel_new[VEL_WL-2:0]);
    w_goal          = !i_pos_data[POS_WL-1] && (i_pos_data[POS_WL-2:0] >= GOAL_MAG);
  end

  assign o_vel_ena    = r_vel_ena;
  assign o_vel_pos    = r_pos;
  assign o_vel_vel    = r_vel;
  assign o_vel_act    = r_act;
  assign o_pos_ena    = r_pos_ena;
  assign o_pos_pos    = r_pos;
  assign o_pos_vel    = r_vel_new;
  assign o_obs_valid  = (r_state == S_OUT);
  assign o_obs_pos    = r_pos;
  assign o_obs_vel    = r_vel;
  assign o_reward     = r_reward;
  assign o_terminated = r_term;
  assign o_truncated  = r_trunc;
  assign o_error      = (r_state == S_ERR);

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_state   <= S_IDLE;
      r_pos     <= '0;
      r_vel     <= '0;
      r_vel_new <= '0;
      r_act     <= '0;
      r_cnt     <= '0;
      r_wdog    <= '0;
      r_reward  <= '0;
      r_term    <= 1'b0;
      r_trunc   <= 1'b0;
      r_vel_ena <= 1'b0;
      r_pos_ena <= 1'b0;
    end else begin
      r_vel_ena <= 1'b0;
      r_pos_ena <= 1'b0;
      case (r_state)
        S_IDLE, S_READY, S_DONE: begin
          if (w_rst_xfer) begin
            r_pos    <= i_init_pos;
            r_vel    <= '0;
            r_cnt    <= '0;
            r_reward <= '0;
            r_term   <= 1'b0;
            r_trunc  <= 1'b0;
            r_state  <= S_OUT;
          end else if (w_act_xfer) begin
            r_act     <= i_act;
            r_cnt     <= r_cnt + CNT_WL'(1);
            r_wdog    <= '0;
            r_vel_ena <= 1'b1;
            r_state   <= S_VEL;
          end else begin
            r_state <= r_state;
          end
        end
        S_VEL: begin
          if (i_vel_valid) begin
            r_vel_new <= i_vel_data;
            r_wdog    <= '0;
            r_pos_ena <= 1'b1;
            r_state   <= S_POS;
          end else if (r_wdog == WD_WL'(TIMEOUT)) begin
            r_state <= S_ERR;
          end else begin
            r_wdog <= r_wdog + WD_WL'(1);
          end
        end
        S_POS: begin
          if (i_pos_valid) begin
            r_pos    <= i_pos_data;
            r_vel    <= w_wall_hit ? '0 : r_vel_new;
            r_reward <= REW_STEP;
            r_term   <= w_goal;
            r_trunc  <= (r_cnt == CNT_WL'(MAX_STEPS));
            r_state  <= S_OUT;
          end else if (r_wdog == WD_WL'(TIMEOUT)) begin
            r_state <= S_ERR;
          end else begin
            r_wdog <= r_wdog + WD_WL'(1);
          end
        end
        S_OUT: begin
          if (i_obs_ready) begin
            r_state <= (r_term || r_trunc) ? S_DONE : S_READY;
          end else begin
            r_state <= S_OUT;
          end
        end
        S_ERR: begin
          r_state <= S_ERR;
        end
        default: begin
          r_state <= S_IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_mountaincar_step_ctrl.sv
// Directed, table-driven bench for mountaincar_step_ctrl with hand-driven unit stubs.
module tb_mountaincar_step_ctrl;

  logic        clk = 1'b0;
  logic        i_rst;
  logic        i_rst_req_valid;
  logic        o_rst_req_ready;
  logic [31:0] i_init_pos;
  logic        i_act_valid;
  logic        o_act_ready;
  logic [1:0]  i_act;
  logic        o_vel_ena;
  logic [31:0] o_vel_pos;
  logic [31:0] o_vel_vel;
  logic [1:0]  o_vel_act;
  logic        i_vel_valid;
  logic [31:0] i_vel_data;
  logic        o_pos_ena;
  logic [31:0] o_pos_pos;
  logic [31:0] o_pos_vel;
  logic        i_pos_valid;
  logic [31:0] i_pos_data;
  logic        o_obs_valid;
  logic        i_obs_ready;
  logic [31:0] o_obs_pos;
  logic [31:0] o_obs_vel;
  logic [31:0] o_reward;
  logic        o_terminated;
  logic        o_truncated;
  logic        o_error;

  mountaincar_step_ctrl dut (
    .i_clk(clk), .i_rst(i_rst),
    .i_rst_req_valid(i_rst_req_valid), .o_rst_req_ready(o_rst_req_ready),
    .i_init_pos(i_init_pos),
    .i_act_valid(i_act_valid), .o_act_ready(o_act_ready), .i_act(i_act),
    .o_vel_ena(o_vel_ena), .o_vel_pos(o_vel_pos), .o_vel_vel(o_vel_vel), .o_vel_act(o_vel_act),
    .i_vel_valid(i_vel_valid), .i_vel_data(i_vel_data),
    .o_pos_ena(o_pos_ena), .o_pos_pos(o_pos_pos), .o_pos_vel(o_pos_vel),
    .i_pos_valid(i_pos_valid), .i_pos_data(i_pos_data),
    .o_obs_valid(o_obs_valid), .i_obs_ready(i_obs_ready),
    .o_obs_pos(o_obs_pos), .o_obs_vel(o_obs_vel), .o_reward(o_reward),
    .o_terminated(o_terminated), .o_truncated(o_truncated), .o_error(o_error)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [1:0]  act;
    int          lv;
    int          lp;
    int          hold;
    logic [31:0] vel_in;
    logic [31:0] pos_in;
    logic [31:0] exp_vel;
    logic        exp_term;
  } vec_t;

  vec_t        vecs[6];
  int          n_checks = 0;
  int          n_errors = 0;
  int          vel_pulses;
  int          pos_pulses;
  logic [31:0] exp_pos;
  logic [31:0] exp_vel_st;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%08h expected 0x%08h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
    if (o_vel_ena) vel_pulses++;
    if (o_pos_ena) pos_pulses++;
  endtask

  task automatic episode_reset(input logic [31:0] pos);
    chk("rst_req_ready", {31'd0, o_rst_req_ready}, 32'd1);
    i_rst_req_valid = 1'b1;
    i_init_pos      = pos;
    tick();
    i_rst_req_valid = 1'b0;
    chk("rst_obs_valid", {31'd0, o_obs_valid}, 32'd1);
    chk("rst_obs_pos", o_obs_pos, pos);
    chk("rst_obs_vel", o_obs_vel, 32'h0);
    chk("rst_reward", o_reward, 32'h0);
    chk("rst_flags", {30'd0, o_terminated, o_truncated}, 32'd0);
    i_obs_ready = 1'b1;
    tick();
    i_obs_ready = 1'b0;
    chk("act_ready_after_rst", {31'd0, o_act_ready}, 32'd1);
    exp_pos    = pos;
    exp_vel_st = 32'h0;
  endtask

  task automatic do_step(input logic [1:0] act, input int lv, input int lp, input int hold,
                         input logic [31:0] vel_in, input logic [31:0] pos_in,
                         input logic [31:0] exp_vel, input logic exp_term, input logic exp_trunc);
    chk("step_act_ready", {31'd0, o_act_ready}, 32'd1);
    vel_pulses  = 0;
    pos_pulses  = 0;
    i_act       = act;
    i_act_valid = 1'b1;
    tick();
    i_act_valid = 1'b0;
    chk("vel_ena", {31'd0, o_vel_ena}, 32'd1);
    chk("vel_act", {30'd0, o_vel_act}, {30'd0, act});
    chk("vel_pos", o_vel_pos, exp_pos);
    chk("vel_vel", o_vel_vel, exp_vel_st);
    chk("busy_readies", {30'd0, o_act_ready, o_rst_req_ready}, 32'd0);
    repeat (lv) tick();
    i_vel_valid = 1'b1;
    i_vel_data  = vel_in;
    tick();
    i_vel_valid = 1'b0;
    chk("pos_ena", {31'd0, o_pos_ena}, 32'd1);
    chk("pos_pos", o_pos_pos, exp_pos);
    chk("pos_vel", o_pos_vel, vel_in);
    repeat (lp) tick();
    chk("obs_early", {31'd0, o_obs_valid}, 32'd0);
    i_pos_valid = 1'b1;
    i_pos_data  = pos_in;
    tick();
    i_pos_valid = 1'b0;
    chk("obs_valid", {31'd0, o_obs_valid}, 32'd1);
    chk("obs_pos", o_obs_pos, pos_in);
    chk("obs_vel", o_obs_vel, exp_vel);
    chk("reward", o_reward, 32'hBF800000);
    chk("terminated", {31'd0, o_terminated}, {31'd0, exp_term});
    chk("truncated", {31'd0, o_truncated}, {31'd0, exp_trunc});
    for (int h = 0; h < hold; h++) begin
      tick();
      chk("hold_valid", {31'd0, o_obs_valid}, 32'd1);
      chk("hold_pos", o_obs_pos, pos_in);
      chk("hold_vel", o_obs_vel, exp_vel);
      chk("hold_reward", o_reward, 32'hBF800000);
    end
    chk("vel_pulses", vel_pulses, 32'd1);
    chk("pos_pulses", pos_pulses, 32'd1);
    i_obs_ready = 1'b1;
    tick();
    i_obs_ready = 1'b0;
    exp_pos    = pos_in;
    exp_vel_st = exp_vel;
  endtask

  initial begin
    vecs[0] = '{act: 2'd2, lv: 10, lp: 3, hold: 5, vel_in: 32'h3A83126F, pos_in: 32'hBEFF7CEE, exp_vel: 32'h3A83126F, exp_term: 1'b0};
    vecs[1] = '{act: 2'd0, lv: 1,  lp: 1, hold: 0, vel_in: 32'hBC000000, pos_in: 32'hBF99999A, exp_vel: 32'h00000000, exp_term: 1'b0};
    vecs[2] = '{act: 2'd1, lv: 2,  lp: 0, hold: 1, vel_in: 32'h3C000000, pos_in: 32'hBF99999A, exp_vel: 32'h3C000000, exp_term: 1'b0};
    vecs[3] = '{act: 2'd3, lv: 0,  lp: 2, hold: 0, vel_in: 32'h80000000, pos_in: 32'hBF99999A, exp_vel: 32'h80000000, exp_term: 1'b0};
    vecs[4] = '{act: 2'd1, lv: 3,  lp: 1, hold: 0, vel_in: 32'h3C000000, pos_in: 32'hBF800000, exp_vel: 32'h3C000000, exp_term: 1'b0};
    vecs[5] = '{act: 2'd2, lv: 0,  lp: 0, hold: 0, vel_in: 32'h3C000000, pos_in: 32'h3EFFFFFF, exp_vel: 32'h3C000000, exp_term: 1'b0};

    i_rst = 1'b1; i_rst_req_valid = 1'b0; i_init_pos = 32'h0; i_act_valid = 1'b0; i_act = 2'd0;
    i_vel_valid = 1'b0; i_vel_data = 32'h0; i_pos_valid = 1'b0; i_pos_data = 32'h0; i_obs_ready = 1'b0;
    exp_pos = 32'h0; exp_vel_st = 32'h0; vel_pulses = 0; pos_pulses = 0;
    tick();
    tick();
    i_rst = 1'b0;
    tick();
    chk("reset_valids", {29'd0, o_obs_valid, o_vel_ena, o_pos_ena}, 32'd0);
    chk("reset_flags", {29'd0, o_terminated, o_truncated, o_error}, 32'd0);
    chk("reset_readies", {30'd0, o_act_ready, o_rst_req_ready}, 32'd1);
    chk("reset_obs_pos", o_obs_pos, 32'h0);
    chk("reset_obs_vel", o_obs_vel, 32'h0);
    chk("reset_reward", o_reward, 32'h0);

    episode_reset(32'hBF000000);
    for (int i = 0; i < 6; i++) begin
      do_step(vecs[i].act, vecs[i].lv, vecs[i].lp, vecs[i].hold, vecs[i].vel_in,
              vecs[i].pos_in, vecs[i].exp_vel, vecs[i].exp_term, 1'b0);
    end

    // Goal reached, then the controller must refuse actions until an episode reset.
    do_step(2'd2, 1, 1, 0, 32'h3C000000, 32'h3F000000, 32'h3C000000, 1'b1, 1'b0);
    i_act_valid = 1'b1;
    vel_pulses  = 0;
    repeat (3) begin
      tick();
      chk("done_act_ready", {31'd0, o_act_ready}, 32'd0);
      chk("done_rst_ready", {31'd0, o_rst_req_ready}, 32'd1);
    end
    chk("done_no_launch", vel_pulses, 32'd0);
    i_act_valid = 1'b0;
    episode_reset(32'hBF000000);

    // Simultaneous reset and action: reset wins.
    i_act_valid = 1'b1; i_act = 2'd1; i_rst_req_valid = 1'b1; i_init_pos = 32'hBF19999A;
    #1;
    chk("both_act_ready", {31'd0, o_act_ready}, 32'd0);
    tick();
    i_act_valid = 1'b0; i_rst_req_valid = 1'b0;
    chk("both_obs_valid", {31'd0, o_obs_valid}, 32'd1);
    chk("both_obs_pos", o_obs_pos, 32'hBF19999A);
    chk("both_no_vel_ena", {31'd0, o_vel_ena}, 32'd0);
    i_obs_ready = 1'b1;
    tick();
    i_obs_ready = 1'b0;
    exp_pos = 32'hBF19999A; exp_vel_st = 32'h0;

    // Truncation on exactly step 200.
    for (int s = 1; s <= 200; s++) begin
      do_step(2'd1, 0, 0, 0, 32'h0, 32'h0, 32'h0, 1'b0, (s == 200));
    end
    chk("trunc_act_ready", {31'd0, o_act_ready}, 32'd0);

    // Valids arriving exactly TIMEOUT cycles after each launch are accepted.
    episode_reset(32'hBF000000);
    i_act = 2'd0; i_act_valid = 1'b1;
    tick();
    i_act_valid = 1'b0;
    repeat (64) tick();
    i_vel_valid = 1'b1; i_vel_data = 32'h3A000000;
    tick();
    i_vel_valid = 1'b0;
    chk("late_vel_pos_ena", {31'd0, o_pos_ena}, 32'd1);
    chk("late_vel_no_err", {31'd0, o_error}, 32'd0);
    repeat (64) tick();
    i_pos_valid = 1'b1; i_pos_data = 32'h3E000000;
    tick();
    i_pos_valid = 1'b0;
    chk("late_pos_obs", {31'd0, o_obs_valid}, 32'd1);
    chk("late_pos_no_err", {31'd0, o_error}, 32'd0);
    i_obs_ready = 1'b1;
    tick();
    i_obs_ready = 1'b0;

    // Velocity unit never answers.
    i_act = 2'd2; i_act_valid = 1'b1;
    tick();
    i_act_valid = 1'b0;
    chk("to_launch", {31'd0, o_vel_ena}, 32'd1);
    repeat (64) tick();
    chk("to_not_yet", {31'd0, o_error}, 32'd0);
    tick();
    chk("to_error", {31'd0, o_error}, 32'd1);
    i_vel_valid = 1'b1; i_pos_valid = 1'b1; i_rst_req_valid = 1'b1; i_act_valid = 1'b1;
    tick();
    tick();
    i_vel_valid = 1'b0; i_pos_valid = 1'b0; i_rst_req_valid = 1'b0; i_act_valid = 1'b0;
    chk("err_sticky", {31'd0, o_error}, 32'd1);
    chk("err_outputs", {27'd0, o_obs_valid, o_vel_ena, o_pos_ena, o_act_ready, o_rst_req_ready}, 32'd0);
    i_rst = 1'b1;
    tick();
    i_rst = 1'b0;
    chk("err_cleared", {31'd0, o_error}, 32'd0);
    chk("err_idle_ready", {31'd0, o_rst_req_ready}, 32'd1);

    // Reset in the middle of S_POS; the late position result is ignored.
    episode_reset(32'hBF000000);
    i_act = 2'd1; i_act_valid = 1'b1;
    tick();
    i_act_valid = 1'b0;
    i_vel_valid = 1'b1; i_vel_data = 32'h3C000000;
    tick();
    i_vel_valid = 1'b0;
    chk("mid_pos_ena", {31'd0, o_pos_ena}, 32'd1);
    i_rst = 1'b1;
    tick();
    i_rst = 1'b0;
    i_pos_valid = 1'b1; i_pos_data = 32'h3F000000;
    tick();
    i_pos_valid = 1'b0;
    tick();
    chk("mid_obs_valid", {31'd0, o_obs_valid}, 32'd0);
    chk("mid_readies", {30'd0, o_act_ready, o_rst_req_ready}, 32'd1);
    chk("mid_obs_pos", o_obs_pos, 32'h0);
    chk("mid_flags", {29'd0, o_terminated, o_truncated, o_error}, 32'd0);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

endmodule
